// File: rtl/vend_ctrl.sv
// ============================================================================
// Module   : vend_ctrl
// Brief    : Vending controller -- credit accumulation, vend handshake with
//            timeout, and change dispensing in fixed-size beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vend_ctrl #(
    parameter logic [7:0]  CHANGE_UNIT  = 8'd5,
    parameter logic [15:0] VEND_TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    input  logic       sel_valid,
    input  logic [7:0] sel_price,
    input  logic       cancel,
    input  logic       vend_ack,
    input  logic       change_ready,
    output logic [7:0] credit,
    output logic       vend_req,
    output logic       change_valid,
    output logic [7:0] change_coin,
    output logic       coin_reject,
    output logic       sel_deny,
    output logic       vend_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_credit;
    logic [7:0]  r_price;
    logic [7:0]  r_change_coin;
    logic [15:0] r_timer;
    logic        r_vend_req;
    logic        r_change_valid;
    logic        r_coin_reject;
    logic        r_sel_deny;
    logic        r_vend_fault;

    logic        w_can_purchase;
    logic [8:0]  w_coin_sum;
    logic        w_coin_fits;
    logic [7:0]  w_vend_left;
    logic [7:0]  w_change_left;
    logic        w_timeout;

    function automatic logic [7:0] beat_of(input logic [7:0] amount);
        return (amount < CHANGE_UNIT) ? amount : CHANGE_UNIT;
    endfunction

    assign w_can_purchase = (r_credit >= sel_price) && (sel_price != 8'd0);
    assign w_coin_sum     = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_coin_fits    = ~w_coin_sum[8];
    assign w_vend_left    = r_credit - r_price;
    assign w_change_left  = r_credit - r_change_coin;
    assign w_timeout      = (r_timer == VEND_TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_credit       <= 8'd0;
            r_price        <= 8'd0;
            r_change_coin  <= 8'd0;
            r_timer        <= 16'd0;
            r_vend_req     <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_sel_deny     <= 1'b0;
            r_vend_fault   <= 1'b0;
        end else begin
            r_coin_reject <= 1'b0;
            r_sel_deny    <= 1'b0;
            case (r_state)
                IDLE: begin
                    // cancel pre-empts everything; any coin arriving alongside a
                    // higher-priority event is handed back
                    if (cancel) begin
                        r_coin_reject <= coin_valid;
                        if (r_credit != 8'd0) begin
                            r_state        <= CHANGE;
                            r_change_valid <= 1'b1;
                            r_change_coin  <= beat_of(r_credit);
                        end
                    end else if (sel_valid) begin
                        r_coin_reject <= coin_valid;
                        if (w_can_purchase) begin
                            r_price    <= sel_price;
                            r_timer    <= 16'd0;
                            r_vend_req <= 1'b1;
                            r_state    <= VEND;
                        end else begin
                            r_sel_deny <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (w_coin_fits)
                            r_credit <= w_coin_sum[7:0];
                        else
                            r_coin_reject <= 1'b1;
                    end
                end

                VEND: begin
                    r_coin_reject <= coin_valid;
                    r_sel_deny    <= sel_valid;
                    if (vend_ack) begin
                        r_credit   <= w_vend_left;
                        r_vend_req <= 1'b0;
                        if (w_vend_left != 8'd0) begin
                            r_state        <= CHANGE;
                            r_change_valid <= 1'b1;
                            r_change_coin  <= beat_of(w_vend_left);
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_timeout) begin
                        // dispenser never answered: refund the whole credit
                        r_vend_req     <= 1'b0;
                        r_vend_fault   <= 1'b1;
                        r_state        <= CHANGE;
                        r_change_valid <= 1'b1;
                        r_change_coin  <= beat_of(r_credit);
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                CHANGE: begin
                    r_coin_reject <= coin_valid;
                    r_sel_deny    <= sel_valid;
                    if (change_ready) begin
                        r_credit <= w_change_left;
                        if (w_change_left == 8'd0) begin
                            r_change_valid <= 1'b0;
                            r_change_coin  <= 8'd0;
                            r_state        <= IDLE;
                        end else begin
                            r_change_coin <= beat_of(w_change_left);
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign credit       = r_credit;
    assign vend_req     = r_vend_req;
    assign change_valid = r_change_valid;
    assign change_coin  = r_change_coin;
    assign coin_reject  = r_coin_reject;
    assign sel_deny     = r_sel_deny;
    assign vend_fault   = r_vend_fault;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl.sv
// ============================================================================
// Module   : tb_vend_ctrl
// Brief    : Directed scenarios plus randomized traffic for vend_ctrl,
//            compared cycle by cycle against a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vend_ctrl;

    localparam logic [7:0]  c_unit    = 8'd5;
    localparam int          c_timeout = 40;

    localparam int c_m_idle   = 0;
    localparam int c_m_vend   = 1;
    localparam int c_m_change = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       sel_valid;
    logic [7:0] sel_price;
    logic       cancel;
    logic       vend_ack;
    logic       change_ready;
    logic [7:0] credit;
    logic       vend_req;
    logic       change_valid;
    logic [7:0] change_coin;
    logic       coin_reject;
    logic       sel_deny;
    logic       vend_fault;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: money held, what the machine is doing, and pulses
    int m_credit;
    int m_mode;
    int m_price;
    int m_waited;
    bit m_fault;
    bit m_rej;
    bit m_deny;

    vend_ctrl #(
        .CHANGE_UNIT  (c_unit),
        .VEND_TIMEOUT (16'(c_timeout))
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_price    (sel_price),
        .cancel       (cancel),
        .vend_ack     (vend_ack),
        .change_ready (change_ready),
        .credit       (credit),
        .vend_req     (vend_req),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .coin_reject  (coin_reject),
        .sel_deny     (sel_deny),
        .vend_fault   (vend_fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beat(input int amount);
        return (amount < int'(c_unit)) ? amount : int'(c_unit);
    endfunction

    task automatic model_reset();
        m_credit = 0; m_mode = c_m_idle; m_price = 0; m_waited = 0;
        m_fault = 0; m_rej = 0; m_deny = 0;
    endtask

    task automatic model_step(input bit cv, input int cval, input bit sv, input int sp,
                              input bit cn, input bit ak, input bit rd);
        m_rej = 0; m_deny = 0;
        if (m_mode == c_m_idle) begin
            if (cn) begin
                m_rej = cv;
                if (m_credit > 0) m_mode = c_m_change;
            end else if (sv) begin
                m_rej = cv;
                if (sp != 0 && m_credit >= sp) begin
                    m_price = sp; m_waited = 0; m_mode = c_m_vend;
                end else m_deny = 1;
            end else if (cv) begin
                if (m_credit + cval > 255) m_rej = 1;
                else m_credit = m_credit + cval;
            end
        end else if (m_mode == c_m_vend) begin
            m_rej = cv; m_deny = sv;
            if (ak) begin
                m_credit = m_credit - m_price;
                m_mode = (m_credit > 0) ? c_m_change : c_m_idle;
            end else begin
                m_waited++;
                if (m_waited == c_timeout) begin
                    m_fault = 1; m_mode = c_m_change;
                end
            end
        end else begin
            m_rej = cv; m_deny = sv;
            if (rd) begin
                m_credit = m_credit - beat(m_credit);
                if (m_credit == 0) m_mode = c_m_idle;
            end
        end
    endtask

    task automatic compare_all();
        check_val("credit", credit, m_credit);
        check_val("vend_req", vend_req, m_mode == c_m_vend);
        check_val("change_valid", change_valid, m_mode == c_m_change);
        check_val("change_coin", change_coin, (m_mode == c_m_change) ? beat(m_credit) : 0);
        check_val("coin_reject", coin_reject, m_rej);
        check_val("sel_deny", sel_deny, m_deny);
        check_val("vend_fault", vend_fault, m_fault);
    endtask

    // one clock of stimulus; called #1 after a rising edge
    task automatic step(input bit cv, input int cval, input bit sv, input int sp,
                        input bit cn, input bit ak, input bit rd);
        coin_valid = cv; coin_value = 8'(cval);
        sel_valid = sv; sel_price = 8'(sp);
        cancel = cn; vend_ack = ak; change_ready = rd;
        @(posedge clk);
        model_step(cv, cval, sv, sp, cn, ak, rd);
        #1;
        compare_all();
        coin_valid = 0; sel_valid = 0; cancel = 0; vend_ack = 0; change_ready = 0;
    endtask

    task automatic coin(input int v);
        step(1, v, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, rd);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        compare_all();
    endtask

    initial begin
        int coins[7] = '{1, 5, 10, 25, 50, 100, 200};
        rst_n = 0; coin_valid = 0; coin_value = 0; sel_valid = 0; sel_price = 0;
        cancel = 0; vend_ack = 0; change_ready = 0;
        do_reset();

        // coins 25,25,50 then buy 75, ack after 3 cycles, change 5 x 5
        coin(25); coin(25); coin(50);
        check_val("sum_100", credit, 100);
        step(0, 0, 1, 75, 0, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check_val("after_vend", credit, 25);
        idle(5, 1);
        check_val("drained", credit, 0);

        // overflow reject and zero-price deny
        do_reset();
        coin(200); coin(50); coin(10);
        check_val("overflow_hold", credit, 250);
        step(0, 0, 1, 0, 0, 0, 0);

        // denied selection, cancel with stalled dispenser
        do_reset();
        coin(25); coin(5);
        step(0, 0, 1, 40, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, bit'(i % 2));
        check_val("cancel_done", credit, 0);

        // dispenser timeout and full refund
        do_reset();
        coin(50); coin(10);
        step(0, 0, 1, 60, 0, 0, 0);
        idle(c_timeout, 0);
        check_val("fault_set", vend_fault, 1);
        idle(12, 1);
        check_val("refund_done", credit, 0);

        // odd refund and same-cycle priority
        do_reset();
        coin(5); coin(1); coin(1);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(2, 1);
        coin(10);
        step(1, 5, 1, 5, 1, 0, 0);
        check_val("prio_reject", coin_reject, 1);

        // asynchronous reset while dispensing change
        do_reset();
        coin(50);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        #2 rst_n = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1 compare_all();

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bit cv, sv, cn, ak, rd;
            int cval, sp;
            cv   = ($urandom_range(0, 99) < 30);
            cval = coins[$urandom_range(0, 6)];
            sv   = ($urandom_range(0, 99) < 12);
            sp   = $urandom_range(0, 120);
            cn   = ($urandom_range(0, 99) < 6);
            ak   = ($urandom_range(0, 99) < 10);
            rd   = ($urandom_range(0, 99) < 60);
            step(cv, cval, sv, sp, cn, ak, rd);
            if (i == 1250) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
